dijkstra_path_engine: RTL
=========================

# dijkstra_path_engine

Path-planning responder for the mission handler. It accepts a route request (`CPU_start`, `start_point`, `end_point`) and computes the shortest path over a programmable arena graph using a sequential Dijkstra search. It then walks the bot along that path one node at a time, driving `curr_node`, which the mission handler compares against `end_point` to detect arrival. It sits between the mission handler and the line-follow/motion controller.

## Interface
Parameters:
- `NUM_NODES`, 32: node slots; node ids are 5 bits.
- `MAX_DEG`, 4: neighbour slots per node.
- `W_BITS`, 4: edge weight width.

Ports:
- `clk_3125KHz`  in  1  sole clock.
- `rst_n`  in  1  reset; synchronous and active-low.
- `map_we`  in  1  map write strobe; honoured in IDLE only.
- `map_addr`  in  7  address `{node[4:0], slot[1:0]}`.
- `map_data`  in  10  entry `{valid, nbr[4:0], weight[3:0]}`.
- `CPU_start`  in  1  request level, held high by the handler until arrival.
- `start_point`  in  5  source node, sampled at accept.
- `end_point`  in  5  destination node, sampled at accept.
- `node_reached`  in  1  one-cycle pulse from motion control when `next_node` is reached.
- `curr_node`  out  5  node the bot is at.
- `next_node`  out  5  node the bot must drive to; meaningful only while `path_valid` is high.
- `path_valid`  out  1  high in RUN.
- `busy`  out  1  high from accept until DONE or FAIL.
- `no_path`  out  1  high in FAIL.

## Operation
- Map RAM holds `NUM_NODES*MAX_DEG` entries; entries with valid=0 are ignored. Edges are directed, so undirected links are written twice.
- Distances are 8 bits. 8'hFF means infinity. Additions saturate at 8'hFE.
- States and transitions:
  - IDLE: waits for `CPU_start`=1. On accept, latches src/dst and sets `curr_node`<=src. If src==dst, goes to DONE; otherwise goes to INIT.
  - INIT: takes `NUM_NODES` cycles. Sets dist=FF, visited=0, prev=self for every node, then dist[src]=0.
  - SCAN: takes `NUM_NODES` cycles. Finds the unvisited node with the minimum dist; ties go to the lowest index.
    - If min==FF, goes to FAIL.
    - If the min node is dst, goes to TRACE.
    - Otherwise marks the node visited and goes to RELAX.
  - RELAX: takes `MAX_DEG` cycles, one slot per cycle. For each valid neighbour: if dist[u]+w < dist[v] (strict), then dist[v] and prev[v] are updated. Then returns to SCAN.
  - TRACE: follows prev from dst back to src, pushing one node per cycle onto a `NUM_NODES`-deep path stack. Then goes to RUN with `next_node` set to the first hop.
  - RUN: on `node_reached`, sets `curr_node`<=`next_node`. If that node is dst, goes to DONE; otherwise pops the next hop.
  - DONE: holds. When `CPU_start`=0, returns to IDLE.
  - FAIL: holds `no_path`=1. When `CPU_start`=0, returns to IDLE.
- Boundary conditions:
  - `CPU_start` falling in any of INIT, SCAN, RELAX, TRACE or RUN aborts to IDLE. `curr_node` is retained.
  - `node_reached` outside RUN is ignored.
  - `map_we` outside IDLE is ignored.
  - Any id ≥ `NUM_NODES` presented on `start_point` or `end_point` goes to FAIL.

## Timing
- Reset values: `curr_node`=0, `next_node`=0, `path_valid`=0, `busy`=0, `no_path`=0. The map RAM is not cleared.
- Accept takes effect the cycle after `CPU_start` is seen high in IDLE; `busy` rises that same cycle.
- Worst-case plan latency is `NUM_NODES` + V×(`NUM_NODES`+`MAX_DEG`) + path_len + 1 cycles, where V is the number of visited nodes.
  - Bound at the default parameters: 32 + 32×36 + 32 + 1 = 1217 cycles, about 390 µs.
- `path_valid` and `next_node` are registered and update the cycle after TRACE completes.
- `curr_node` updates one cycle after `node_reached`.
- `busy` falls in the same cycle that `curr_node`=dst is presented.

## Configuration
- `DIJKSTRA_WEIGHTED_EN` defined: relaxation uses the weight field of each map entry.
- Not defined: every valid edge weighs 1, so the search is a minimum-hop search. The weight field is ignored and its adder input is tied to 1.

## Test plan
Base map for scenarios 1 and 2: chain 0↔1↔2↔3 with weight 1 per edge, plus a shortcut 0↔3 with weight 5.

1. Weighted build, base map, request 0→3: path 1,2,3; `busy` falls and `curr_node`=3 after 3 `node_reached` pulses.
2. Unweighted build, same map and request 0→3: `next_node`=3, reached after 1 pulse.
3. Request 5→5: `curr_node`=5 and `busy`=0 the cycle after accept, with no RUN phase.
4. Node 9 left without edges, request 0→9: `no_path`=1 within 1217 cycles. Dropping `CPU_start` returns to IDLE and clears `no_path`.
5. Drop `CPU_start` during RUN after 1 hop: returns to IDLE with `curr_node`=1 retained. A new request 1→3 then yields path 2,3.
6. Assert `rst_n`=0 mid-SCAN: all outputs reach their reset values at the next edge, and `map_we` pulses issued during the search are ignored.

Source files
------------

// File: rtl/dijkstra_path_engine.sv
// Shortest-path planner: sequential Dijkstra over a map RAM, then steps curr_node hop by hop on node_reached.
// Plan latency <= NUM_NODES + V*(NUM_NODES+MAX_DEG) + path_len + 1; CPU_start low aborts; `DIJKSTRA_WEIGHTED_EN selects weighted edges.
module dijkstra_path_engine #(
  parameter int NUM_NODES = 32,
  parameter int MAX_DEG   = 4,
  parameter int W_BITS    = 4
) (
  input  logic              clk_3125KHz,
  input  logic              rst_n,
  input  logic              map_we,
  input  logic [6:0]        map_addr,
  input  logic [W_BITS+5:0] map_data,
  input  logic              CPU_start,
  input  logic [4:0]        start_point,
  input  logic [4:0]        end_point,
  input  logic              node_reached,
  output logic [4:0]        curr_node,
  output logic [4:0]        next_node,
  output logic              path_valid,
  output logic              busy,
  output logic              no_path
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SCAN, S_RELAX, S_TRACE, S_RUN, S_DONE, S_FAIL
  } state_t;

  localparam logic [4:0] LAST_NODE = 5'(NUM_NODES - 1);
  localparam logic [1:0] LAST_SLOT = 2'(MAX_DEG - 1);

  logic [W_BITS+5:0] map_mem   [NUM_NODES*MAX_DEG];
  logic [7:0]        dist_mem  [NUM_NODES];
  logic [4:0]        prev_mem  [NUM_NODES];
  logic [4:0]        stack_mem [NUM_NODES];

  state_t               state_q, state_d;
  logic [4:0]           src_q, src_d, dst_q, dst_d;
  logic [4:0]           cnt_q, cnt_d, u_q, u_d;
  logic [7:0]           min_dist_q, min_dist_d;
  logic [4:0]           min_idx_q, min_idx_d;
  logic [4:0]           trace_q, trace_d;
  logic [5:0]           sp_q, sp_d;
  logic [NUM_NODES-1:0] visited_q, visited_d;
  logic [4:0]           curr_node_q, curr_node_d, next_node_q, next_node_d;
  logic                 path_valid_q, path_valid_d, busy_q, busy_d, no_path_q, no_path_d;

  logic       dist_we, prev_we, stack_we;
  logic [4:0] dist_wa, prev_wa, prev_wd, stack_wa, stack_wd;
  logic [7:0] dist_wd;

  logic [W_BITS+5:0] map_entry;
  logic              e_vld;
  logic [4:0]        e_nbr;
  logic [8:0]        e_w, sum;
  logic [7:0]        relax_dist, scan_dist, cand_dist;
  logic [4:0]        cand_idx;
  logic              improve, take;
  logic [5:0]        sp_m1;

  assign map_entry = map_mem[{u_q, cnt_q[1:0]}];
  assign e_vld     = map_entry[W_BITS+5];
  assign e_nbr     = map_entry[W_BITS+4:W_BITS];
`ifdef DIJKSTRA_WEIGHTED_EN
  assign e_w = 9'(map_entry[W_BITS-1:0]);
`else
  logic unused_weight;
  assign unused_weight = ^map_entry[W_BITS-1:0];
  assign e_w = 9'd1;
`endif
  // Saturate at FE so a finite distance never aliases the FF "unreached" marker.
  assign sum        = {1'b0, dist_mem[u_q]} + e_w;
  assign relax_dist = (sum >= 9'h0FE) ? 8'hFE : sum[7:0];
  assign improve    = e_vld && (relax_dist < dist_mem[e_nbr]);

  assign scan_dist = dist_mem[cnt_q];
  assign take      = !visited_q[cnt_q] && (scan_dist < min_dist_q);
  assign cand_dist = take ? scan_dist : min_dist_q;
  assign cand_idx  = take ? cnt_q : min_idx_q;
  assign sp_m1     = sp_q - 6'd1;

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    dst_d       = dst_q;
    cnt_d       = cnt_q;
    u_d         = u_q;
    min_dist_d  = min_dist_q;
    min_idx_d   = min_idx_q;
    trace_d     = trace_q;
    sp_d        = sp_q;
    visited_d   = visited_q;
    curr_node_d = curr_node_q;
    next_node_d = next_node_q;
    dist_we     = 1'b0;
    dist_wa     = cnt_q;
    dist_wd     = 8'hFF;
    prev_we     = 1'b0;
    prev_wa     = cnt_q;
    prev_wd     = cnt_q;
    stack_we    = 1'b0;
    stack_wa    = sp_q[4:0];
    stack_wd    = trace_q;

    case (state_q)
      S_IDLE: begin
        if (CPU_start) begin
          src_d       = start_point;
          dst_d       = end_point;
          curr_node_d = start_point;
          cnt_d       = '0;
          sp_d        = '0;
          if (int'(start_point) >= NUM_NODES || int'(end_point) >= NUM_NODES) state_d = S_FAIL;
          else if (start_point == end_point) state_d = S_DONE;
          else state_d = S_INIT;
        end
      end
      S_INIT: begin
        dist_we             = 1'b1;
        dist_wd             = (cnt_q == src_q) ? 8'h00 : 8'hFF;
        prev_we             = 1'b1;
        visited_d[cnt_q]    = 1'b0;
        if (cnt_q == LAST_NODE) begin
          state_d    = S_SCAN;
          cnt_d      = '0;
          min_dist_d = 8'hFF;
          min_idx_d  = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_SCAN: begin
        if (cnt_q == LAST_NODE) begin
          cnt_d = '0;
          if (cand_dist == 8'hFF) begin
            state_d = S_FAIL;
          end else if (cand_idx == dst_q) begin
            state_d = S_TRACE;
            trace_d = dst_q;
            sp_d    = '0;
          end else begin
            visited_d[cand_idx] = 1'b1;
            u_d                 = cand_idx;
            state_d             = S_RELAX;
          end
        end else begin
          min_dist_d = cand_dist;
          min_idx_d  = cand_idx;
          cnt_d      = cnt_q + 5'd1;
        end
      end
      S_RELAX: begin
        if (improve) begin
          dist_we = 1'b1;
          dist_wa = e_nbr;
          dist_wd = relax_dist;
          prev_we = 1'b1;
          prev_wa = e_nbr;
          prev_wd = u_q;
        end
        if (cnt_q[1:0] == LAST_SLOT) begin
          state_d    = S_SCAN;
          cnt_d      = '0;
          min_dist_d = 8'hFF;
          min_idx_d  = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_TRACE: begin
        // Stack holds dst..first hop; the top is the first hop once src is hit.
        if (trace_q == src_q) begin
          next_node_d = stack_mem[sp_m1[4:0]];
          sp_d        = sp_m1;
          state_d     = S_RUN;
        end else begin
          stack_we = 1'b1;
          sp_d     = sp_q + 6'd1;
          trace_d  = prev_mem[trace_q];
        end
      end
      S_RUN: begin
        if (node_reached) begin
          curr_node_d = next_node_q;
          if (next_node_q == dst_q) begin
            state_d = S_DONE;
          end else begin
            next_node_d = stack_mem[sp_m1[4:0]];
            sp_d        = sp_m1;
          end
        end
      end
      S_DONE, S_FAIL: begin
        if (!CPU_start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!CPU_start && (state_q inside {S_INIT, S_SCAN, S_RELAX, S_TRACE, S_RUN})) begin
      state_d     = S_IDLE;
      curr_node_d = curr_node_q;
      next_node_d = next_node_q;
    end

    busy_d       = state_d inside {S_INIT, S_SCAN, S_RELAX, S_TRACE, S_RUN};
    path_valid_d = (state_d == S_RUN);
    no_path_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge clk_3125KHz) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      src_q        <= '0;
      dst_q        <= '0;
      cnt_q        <= '0;
      u_q          <= '0;
      min_dist_q   <= 8'hFF;
      min_idx_q    <= '0;
      trace_q      <= '0;
      sp_q         <= '0;
      visited_q    <= '0;
      curr_node_q  <= '0;
      next_node_q  <= '0;
      path_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      no_path_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      cnt_q        <= cnt_d;
      u_q          <= u_d;
      min_dist_q   <= min_dist_d;
      min_idx_q    <= min_idx_d;
      trace_q      <= trace_d;
      sp_q         <= sp_d;
      visited_q    <= visited_d;
      curr_node_q  <= curr_node_d;
      next_node_q  <= next_node_d;
      path_valid_q <= path_valid_d;
      busy_q       <= busy_d;
      no_path_q    <= no_path_d;
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (rst_n && map_we && state_q == S_IDLE) map_mem[map_addr] <= map_data;
    if (dist_we)  dist_mem[dist_wa]   <= dist_wd;
    if (prev_we)  prev_mem[prev_wa]   <= prev_wd;
    if (stack_we) stack_mem[stack_wa] <= stack_wd;
  end

  assign curr_node  = curr_node_q;
  assign next_node  = next_node_q;
  assign path_valid = path_valid_q;
  assign busy       = busy_q;
  assign no_path    = no_path_q;

endmodule
